regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
- Command-side initiator for the 8x8 register file.
- Accepts read/write/dump/clear commands over a valid/ready interface and drives the register file's address, data and write-enable pins.
- Samples the register file's combinational read data and returns it over a valid/ready response channel.
- Provides software clear and full-file dump without software looping.

Parameters:
DW, 8, data width of register file and command/response data
AW, 3, address width; register count is 2**AW

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller accepts command this cycle
cmd_op  in  2  00 read, 01 write, 10 dump, 11 clear
cmd_addr  in  AW  target register (read/write only)
cmd_data  in  DW  write data
rf_n  out  AW  register file address
rf_d  out  DW  register file write data
rf_w  out  1  register file write enable, active-high
rf_q  in  DW  register file read data (combinational from rf_n)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_data  out  DW  read data
rsp_addr  out  AW  register the data came from
rsp_last  out  1  final beat of a response sequence
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at edge):
  - State goes to IDLE; index counter and latched fields clear to 0.
  - rsp_valid, rsp_last, rf_w, busy are 0; rf_n=0, rf_d=0, rsp_data=0, rsp_addr=0.
  - cmd_ready is 0 while rst=1.
  - Reset overrides any in-progress operation, including mid-clear and mid-dump. A stalled response is dropped.
- States: IDLE, WRITE, READ, RSP, CLEAR.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) latches op/addr/data. Transitions:
  - write -> WRITE
  - read -> READ with idx=addr, dump flag 0
  - dump -> READ with idx=0, dump flag 1
  - clear -> CLEAR with idx=0
- WRITE: one cycle with rf_w=1, rf_n=addr, rf_d=data. Next state IDLE; no response.
- READ: one cycle with rf_n=idx and rf_w=0.
  - At the closing edge, rf_q is captured into rsp_data and idx into rsp_addr.
  - rsp_last is set to (!dump | idx==2**AW-1).
  - Next state RSP.
- RSP: rsp_valid=1. rsp_data, rsp_addr and rsp_last are held stable until the handshake (rsp_valid & rsp_ready). On handshake:
  - if dump and not last: idx+1, go to READ
  - otherwise: go to IDLE
- CLEAR: rf_w=1, rf_d=0, rf_n=idx for 2**AW consecutive cycles, idx 0..7. After idx=2**AW-1 go to IDLE. No response.
- rf_n, rf_d, rf_w are Moore outputs of state and latched registers; they never depend combinationally on cmd_* or rsp_ready.
- Outside WRITE/CLEAR, rf_w=0 and rf_d holds its last value.
- Latency, with accept edge = T:
  - write: rf_w high in cycle T+1; cmd_ready high again at T+2.
  - read: rsp_valid high from T+2.
  - dump: with rsp_ready tied 1, one beat every 2 cycles, 8 beats, rsp_last on beat 8.
  - clear: cmd_ready low for 8 cycles after accept.
- Only one command is in flight. cmd_ready=0 in every non-IDLE state, so no command is accepted while a response is pending.
- idx is AW bits. Wrap is never reached because dump/clear terminate at 2**AW-1.
- Reset and command on the same edge: reset wins and the command is not accepted.

Optional Feature:
- REGFILE_CTRL_WRACK_EN defined:
  - After WRITE the FSM enters READ with idx=addr and dump flag 0.
  - The write yields one response beat (rsp_last=1) carrying the read-back value, which must equal the written data.
  - rsp_valid is first high at T+3.
- Not defined: writes produce no response, as above.

Test Plan:
- Reset then write 0xA5 to addr 3 -> rf_w=1 exactly one cycle with rf_n=3, rf_d=0xA5; rsp_valid stays 0 (with WRACK_EN: one beat, rsp_data=0xA5, rsp_addr=3, rsp_last=1).
- Write 0x3C to addr 6, then read addr 6 with rsp_ready held 0 for 5 cycles -> rsp_valid=1, rsp_data=0x3C, rsp_addr=6, rsp_last=1, all stable through the stall; cmd_ready=0 until the handshake.
- Write addr i with value 0x10+i for i=0..7, then dump with rsp_ready=1 -> 8 beats of rsp_addr 0..7 with data 0x10..0x17; rsp_last=1 only on addr 7; beats spaced 2 cycles.
- Clear after the above, then dump -> rf_w high 8 consecutive cycles with rf_n 0..7 and rf_d=0; dump returns 8 beats of 0x00.
- Assert rst for 1 cycle during the 4th clear cycle -> next cycle rf_w=0, busy=0, rsp_valid=0; after release cmd_ready=1; registers 4..7 keep their prior values.
- Hold cmd_valid=1 with a read command while rst=1 -> no handshake; the command is accepted on the first cycle after rst falls.

Source files
------------

// File: rtl/regfile_ctrl_if.sv
// Command, response and register-file pin bundle for regfile_ctrl.
// The master modport is the controller side; slave is the command source / register file side.
interface regfile_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;

  logic [AW-1:0] rf_n;
  logic [DW-1:0] rf_d;
  logic          rf_w;
  logic [DW-1:0] rf_q;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;

  logic          busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rf_q, rsp_ready,
    output cmd_ready, rf_n, rf_d, rf_w, rsp_valid, rsp_data, rsp_addr, rsp_last, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rf_q, rsp_ready,
    input  cmd_ready, rf_n, rf_d, rf_w, rsp_valid, rsp_data, rsp_addr, rsp_last, busy
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Command-side controller for a 2**AW x DW register file: read, write, dump and clear.
// Define REGFILE_CTRL_WRACK_EN to make every write return a read-back response beat.
module regfile_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic           clk,
  input  logic           rst,
  regfile_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, RSP, CLEAR} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_rf_d;
  logic [DW-1:0] r_rsp_data;
  logic [AW-1:0] r_rsp_addr;
  logic          r_rsp_last;
  logic          r_dump;
  logic          w_cmd_hs;
  logic          w_rsp_hs;
  logic          w_idx_max;

  assign w_idx_max = (r_idx == '1);

  // Writes load the target address into idx too, so rf_n is always just idx.
  assign bus.rf_n     = r_idx;
  assign bus.rf_d     = r_rf_d;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_addr = r_rsp_addr;
  assign bus.rsp_last = r_rsp_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rf_w      = 1'b0;
    bus.busy      = (r_state != IDLE);
    w_cmd_hs      = 1'b0;
    w_rsp_hs      = 1'b0;
    case (r_state)
      IDLE: begin
        bus.cmd_ready = !rst;
        w_cmd_hs      = bus.cmd_valid && !rst;
        if (w_cmd_hs) begin
          case (bus.cmd_op)
            2'b01:   w_state_nxt = WRITE;
            2'b11:   w_state_nxt = CLEAR;
            default: w_state_nxt = READ;
          endcase
        end
      end
      WRITE: begin
        bus.rf_w = 1'b1;
`ifdef REGFILE_CTRL_WRACK_EN
        w_state_nxt = READ;
`else
        w_state_nxt = IDLE;
`endif
      end
      READ: w_state_nxt = RSP;
      RSP: begin
        bus.rsp_valid = 1'b1;
        w_rsp_hs      = bus.rsp_ready;
        if (w_rsp_hs) w_state_nxt = (r_dump && !r_rsp_last) ? READ : IDLE;
      end
      CLEAR: begin
        bus.rf_w = 1'b1;
        if (w_idx_max) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_rf_d     <= '0;
      r_rsp_data <= '0;
      r_rsp_addr <= '0;
      r_rsp_last <= 1'b0;
      r_dump     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_hs) begin
            case (bus.cmd_op)
              2'b00: begin
                r_idx  <= bus.cmd_addr;
                r_dump <= 1'b0;
              end
              2'b01: begin
                r_idx  <= bus.cmd_addr;
                r_rf_d <= bus.cmd_data;
                r_dump <= 1'b0;
              end
              2'b10: begin
                r_idx  <= '0;
                r_dump <= 1'b1;
              end
              default: begin
                r_idx  <= '0;
                r_rf_d <= '0;
              end
            endcase
          end
        end
        READ: begin
          r_rsp_data <= bus.rf_q;
          r_rsp_addr <= r_idx;
          r_rsp_last <= !r_dump || w_idx_max;
        end
        RSP: begin
          if (w_rsp_hs && r_dump && !r_rsp_last) r_idx <= r_idx + AW'(1);
        end
        CLEAR: begin
          if (!w_idx_max) r_idx <= r_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8x8 register file attached to the rf pins.
`timescale 1ns/1ps
module tb_regfile_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mem [8];
  int n_checks = 0;
  int n_errs   = 0;

  regfile_ctrl_if #(.DW(8), .AW(3)) bus ();

  regfile_ctrl #(.DW(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rf_q = mem[bus.rf_n];
  always @(posedge clk) if (bus.rf_w === 1'b1) mem[bus.rf_n] <= bus.rf_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data);
    logic hs;
    int n;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      hs = bus.cmd_ready;
      tick();
      n++;
    end while (!hs && n < 20);
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", hs, 1);
  endtask

  task automatic wait_idle();
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 40 && bus.busy; n++) tick();
    chk("idle_wait", bus.busy, 0);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_dump(input logic [7:0] base, input logic [7:0] step);
    int beat;
    logic [7:0] exp_d;
    beat = 0;
    bus.rsp_ready = 1'b1;
    send_cmd(2'b10, 3'd0, 8'd0);
    for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
      if (bus.rsp_valid) begin
        exp_d = base + step * 8'(beat);
        chk("dump_addr", bus.rsp_addr, beat);
        chk("dump_data", bus.rsp_data, exp_d);
        chk("dump_last", bus.rsp_last, (beat == 7));
        chk("dump_gap",  cyc, 2 * beat + 1);
        beat++;
      end
      tick();
    end
    chk("dump_beats", beat, 8);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 3'd0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_last",  bus.rsp_last, 0);
    chk("rst_rf_w",      bus.rf_w, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_rf_n",      bus.rf_n, 0);
    chk("rst_rf_d",      bus.rf_d, 0);
    chk("rst_rsp_data",  bus.rsp_data, 0);
    chk("rst_rsp_addr",  bus.rsp_addr, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.cmd_ready, 1);

    // Write 0xA5 to addr 3
    send_cmd(2'b01, 3'd3, 8'hA5);
    chk("wr_rf_w",  bus.rf_w, 1);
    chk("wr_rf_n",  bus.rf_n, 3);
    chk("wr_rf_d",  bus.rf_d, 8'hA5);
    chk("wr_busy",  bus.busy, 1);
    chk("wr_ready", bus.cmd_ready, 0);
    tick();
    chk("wr_rf_w_one", bus.rf_w, 0);
    chk("wr_rf_d_hold", bus.rf_d, 8'hA5);
    chk("wr_mem3", mem[3], 8'hA5);
    chk("wr_no_rsp", bus.rsp_valid, 0);
`ifdef REGFILE_CTRL_WRACK_EN
    tick();
    chk("wrack_valid", bus.rsp_valid, 1);
    chk("wrack_data",  bus.rsp_data, 8'hA5);
    chk("wrack_addr",  bus.rsp_addr, 3);
    chk("wrack_last",  bus.rsp_last, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("wrack_done", bus.busy, 0);
`else
    chk("wr_ready_again", bus.cmd_ready, 1);
    tick();
    chk("wr_no_rsp2", bus.rsp_valid, 0);
`endif

    // Read with a stalled response
    send_cmd(2'b01, 3'd6, 8'h3C);
    wait_idle();
    send_cmd(2'b00, 3'd6, 8'h00);
    chk("rd_rf_n", bus.rf_n, 6);
    chk("rd_rf_w", bus.rf_w, 0);
    chk("rd_valid_early", bus.rsp_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp", {bus.rsp_valid, bus.rsp_last, bus.rsp_addr, bus.rsp_data}, {1'b1, 1'b1, 3'd6, 8'h3C});
      chk("stall_ready", bus.cmd_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rd_done_valid", bus.rsp_valid, 0);
    chk("rd_done_ready", bus.cmd_ready, 1);

    // Fill then dump
    for (int i = 0; i < 8; i++) begin
      send_cmd(2'b01, 3'(i), 8'h10 + 8'(i));
      wait_idle();
    end
    do_dump(8'h10, 8'h01);

    // Clear then dump
    send_cmd(2'b11, 3'd0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk("clr_rf_w",  bus.rf_w, 1);
      chk("clr_rf_n",  bus.rf_n, i);
      chk("clr_rf_d",  bus.rf_d, 0);
      chk("clr_ready", bus.cmd_ready, 0);
      tick();
    end
    chk("clr_end_w", bus.rf_w, 0);
    chk("clr_end_ready", bus.cmd_ready, 1);
    do_dump(8'h00, 8'h00);

    // Reset during the 4th clear cycle
    for (int i = 0; i < 8; i++) begin
      send_cmd(2'b01, 3'(i), 8'h40 + 8'(i));
      wait_idle();
    end
    send_cmd(2'b11, 3'd0, 8'h00);
    tick();
    tick();
    tick();
    chk("mid_clr_n", bus.rf_n, 3);
    rst = 1'b1;
    tick();
    chk("mid_rst_w",     bus.rf_w, 0);
    chk("mid_rst_busy",  bus.busy, 0);
    chk("mid_rst_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 4; i++) chk("mid_rst_lo", mem[i], 0);
    for (int i = 4; i < 8; i++) chk("mid_rst_hi", mem[i], 8'h40 + 32'(i));

    // Command held through reset
    rst = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 3'd5;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_hold_ready", bus.cmd_ready, 0);
      chk("rst_hold_busy",  bus.busy, 0);
    end
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rst_rel_busy", bus.busy, 1);
    chk("rst_rel_rf_n", bus.rf_n, 5);
    tick();
    chk("rst_rel_valid", bus.rsp_valid, 1);
    chk("rst_rel_data",  bus.rsp_data, 8'h45);
    chk("rst_rel_addr",  bus.rsp_addr, 5);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rst_rel_done", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
